// File: rtl/register_file_mp.sv
// Multi-read-port integer register file with a per-register pending-write scoreboard.
// Optional write-through forwarding on the read ports: define REGFILE_BYPASS_EN.
module register_file_mp #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREGS  = 32,
   parameter int unsigned NUM_RD = 2,
   localparam int unsigned AW    = $clog2(NREGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*XLEN-1:0]   rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [AW-1:0]            wr_addr,
   input  logic [XLEN-1:0]          wr_data,
   input  logic                     wr_clr,
   input  logic                     iss_en,
   input  logic [AW-1:0]            iss_addr,
   input  logic                     flush,
   output logic [NREGS-1:0]         busy_vec
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   // Data array next state; x0 never takes a write.
   always_comb begin
      regs_d = regs_q;
      if (wr_en && (wr_addr != '0)) begin
         regs_d[wr_addr] = wr_data;
      end
      regs_d[0] = '0;
   end

   // Scoreboard next state: flush beats issue, issue beats a same-cycle clear.
   always_comb begin
      busy_d = busy_q;
      for (int unsigned r = 1; r < NREGS; r++) begin
         if (flush) begin
            busy_d[r] = 1'b0;
         end else if (iss_en && (iss_addr == AW'(r))) begin
            busy_d[r] = 1'b1;
         end else if (wr_en && wr_clr && (wr_addr == AW'(r))) begin
            busy_d[r] = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned r = 0; r < NREGS; r++) begin
            regs_q[r] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   // Combinational read ports; reset gating keeps any forwarded value off the bus.
   always_comb begin
      logic [AW-1:0] ra;
      ra      = '0;
      rd_data = '0;
      rd_busy = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         ra = rd_addr[i*AW +: AW];
         if (!reset && (ra != '0)) begin
            rd_data[i*XLEN +: XLEN] = regs_q[ra];
            rd_busy[i]              = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (wr_addr == ra)) begin
               rd_data[i*XLEN +: XLEN] = wr_data;
               rd_busy[i]              = busy_d[ra];
            end
`endif
         end
      end
   end

   assign busy_vec = busy_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: directed scenarios with literal expectations plus
// randomized traffic against an array-based reference model checked every cycle.
module tb_register_file_mp;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned NRD = 4;
   localparam int unsigned AW = 5;

   logic                 clk;
   logic                 reset;
   logic [NRD*AW-1:0]    rd_addr;
   logic [NRD*XLEN-1:0]  rd_data;
   logic [NRD-1:0]       rd_busy;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic [XLEN-1:0]      wr_data;
   logic                 wr_clr;
   logic                 iss_en;
   logic [AW-1:0]        iss_addr;
   logic                 flush;
   logic [NREGS-1:0]     busy_vec;

   int tests = 0;
   int fails = 0;

   register_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NRD)) dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_clr(wr_clr), .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
      .busy_vec(busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: architectural register contents and busy bits.
   logic [XLEN-1:0]  m_regs [NREGS];
   logic [NREGS-1:0] m_busy;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
         m_busy = '0;
      end else begin
         if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
         if (flush) begin
            m_busy = '0;
         end else begin
            if (wr_en && wr_clr) m_busy[wr_addr] = 1'b0;
            if (iss_en) m_busy[iss_addr] = 1'b1;
         end
         m_busy[0] = 1'b0;
      end
   end

   function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
      if (reset || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_addr == a) return wr_data;
`endif
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      if (reset || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_addr == a) begin
         if (flush) return 1'b0;
         if (iss_en && iss_addr == a) return 1'b1;
         if (wr_clr) return 1'b0;
      end
`endif
      return m_busy[a];
   endfunction

   // Every-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clk) begin
      for (int i = 0; i < NRD; i++) begin
         logic [AW-1:0] a;
         a = rd_addr[i*AW +: AW];
         check($sformatf("model rd_data[%0d] a=%0d", i, a), 64'(rd_data[i*XLEN +: XLEN]), 64'(exp_data(a)));
         check($sformatf("model rd_busy[%0d] a=%0d", i, a), 64'(rd_busy[i]), 64'(exp_busy(a)));
      end
      check("model busy_vec", 64'(busy_vec), 64'(reset ? '0 : m_busy));
   end

   task automatic idle();
      wr_en = 0; wr_addr = '0; wr_data = '0; wr_clr = 0;
      iss_en = 0; iss_addr = '0; flush = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int p, input logic [AW-1:0] a);
      rd_addr[p*AW +: AW] = a;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
      return AW'($urandom_range(0, NREGS - 1));
   endfunction

   initial begin
      reset = 1; rd_addr = '0; idle();
      #12 reset = 0;

      // Reset mid-cycle discards contents immediately.
      step();
      wr_en = 1; wr_addr = 5; wr_data = 32'h1; iss_en = 1; iss_addr = 4;
      step();
      idle(); set_rd(0, 5);
      #1;
      check("x5 after write", 64'(rd_data[31:0]), 64'h1);
      check("busy_vec x4", 64'(busy_vec), 64'h10);
      #1 reset = 1;
      #1;
      check("rd_data in reset", 64'(rd_data[63:0]), 64'h0);
      check("busy_vec in reset", 64'(busy_vec), 64'h0);
      #2 reset = 0;
      step();
      check("x5 after reset", 64'(rd_data[31:0]), 64'h0);

      // Write / multi-port read.
      wr_en = 1; wr_addr = 1; wr_data = 32'hAAAABBBB;
      step();
      wr_addr = 31; wr_data = 32'h12345678;
      step();
      idle(); set_rd(0, 1); set_rd(1, 31);
      #1;
      check("rd port1 x31", 64'(rd_data[63:32]), 64'h12345678);
      check("rd port0 x1", 64'(rd_data[31:0]), 64'hAAAABBBB);
      for (int i = 0; i < NRD; i++) set_rd(i, 1);
      #1;
      for (int i = 0; i < NRD; i++)
         check($sformatf("dup read port%0d", i), 64'(rd_data[i*XLEN +: XLEN]), 64'hAAAABBBB);

      // x0 is hardwired.
      wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; iss_en = 1; iss_addr = 0;
      step();
      idle(); rd_addr = '0;
      #1;
      check("x0 data", 64'(rd_data), 64'h0);
      check("x0 busy", 64'(rd_busy), 64'h0);
      check("x0 busy_vec", 64'(busy_vec), 64'h0);

      // Scoreboard priorities.
      iss_en = 1; iss_addr = 3;
      step();
      idle(); set_rd(0, 3);
      #1;
      check("iss x3 busy_vec", 64'(busy_vec), 64'h8);
      check("iss x3 rd_busy", 64'(rd_busy[0]), 64'h1);
      wr_en = 1; wr_addr = 3; wr_data = 32'h33; wr_clr = 1;
      step();
      idle();
      #1;
      check("clr x3", 64'(busy_vec), 64'h0);
      iss_en = 1; iss_addr = 3; wr_en = 1; wr_addr = 3; wr_clr = 1; wr_data = 32'h44;
      step();
      idle();
      #1;
      check("iss beats clr", 64'(busy_vec), 64'h8);
      flush = 1; iss_en = 1; iss_addr = 7;
      step();
      idle();
      #1;
      check("flush beats iss", 64'(busy_vec), 64'h0);

      // Same-cycle write vs read of x6.
      rd_addr = '0; set_rd(0, 6);
      wr_en = 1; wr_addr = 6; wr_data = 32'hDEADBEEF;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("bypass x6", 64'(rd_data[31:0]), 64'hDEADBEEF);
`else
      check("no bypass x6", 64'(rd_data[31:0]), 64'h0);
`endif
      step();
      idle();
      #1;
      check("x6 next cycle", 64'(rd_data[31:0]), 64'hDEADBEEF);

      // Randomized traffic; the negedge process does the checking.
      for (int n = 0; n < 2000; n++) begin
         step();
         reset = 0;
         wr_en = ($urandom_range(0, 1) == 1);
         wr_addr = rnd_addr();
         wr_data = $urandom;
         wr_clr = ($urandom_range(0, 1) == 1);
         iss_en = ($urandom_range(0, 1) == 1);
         iss_addr = rnd_addr();
         flush = ($urandom_range(0, 19) == 0);
         for (int i = 0; i < NRD; i++)
            set_rd(i, ($urandom_range(0, 3) == 0) ? wr_addr : rnd_addr());
         if ($urandom_range(0, 299) == 0) begin
            #2 reset = 1;
         end
      end
      step();
      reset = 0; idle();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
